// File: rtl/ob_cn_sched.sv
// Scheduler in front of the conditional command table: arbitrates cancel vs allocate,
// drains matured commands through a one-deep output register and tracks live occupancy.
module ob_cn_sched #(
    parameter int N         = 4,
    parameter int MAX_DEFER = 3,
    parameter int CMD_W     = 32,
    parameter int UID_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    input  logic [CMD_W-1:0]          in_cmd,
    output logic                      in_accept,
    input  logic                      cxl_vld,
    input  logic [UID_W-1:0]          cxl_uid,
    output logic                      cxl_accept,
    output logic                      cxl_rsp_vld_r,
    output logic [UID_W-1:0]          cxl_rsp_uid_r,
    output logic                      cxl_rsp_hit_r,
    output logic                      tbl_cmd_vld,
    output logic [CMD_W-1:0]          tbl_cmd,
    input  logic                      tbl_full_r,
    output logic                      tbl_cancel,
    output logic [UID_W-1:0]          tbl_cancel_uid,
    input  logic                      tbl_cancel_hit,
    input  logic                      tbl_mtr_vld_r,
    input  logic [CMD_W-1:0]          tbl_mtr_r,
    output logic                      tbl_mtr_accept,
    output logic                      out_vld_r,
    output logic [CMD_W-1:0]          out_cmd_r,
    input  logic                      out_accept,
    output logic [$clog2(N+2)-1:0]    occ_r,
    output logic                      err_r
);

    localparam int OW = $clog2(N+2);
    localparam int DW = $clog2(MAX_DEFER+2);
    // two spare bits: one for the sign of a double decrement, one for headroom above N+1
    localparam int SW = OW + 2;
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);
    localparam logic [SW-1:0] OCC_MAX   = SW'(N + 1);

    logic             alloc_req;
    logic             force_al;
    logic             grant_cxl;
    logic             grant_al;
    logic             pop;
    logic [SW-1:0]    occ_sum;

    logic [DW-1:0]    defer_q, defer_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             err_q, err_d;
    logic             out_vld_q, out_vld_d;
    logic [CMD_W-1:0] out_cmd_q, out_cmd_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [UID_W-1:0] rsp_uid_q, rsp_uid_d;
    logic             rsp_hit_q, rsp_hit_d;

    // Strobes are qualified with rst_n so nothing reaches the table while in reset.
    always_comb begin
        alloc_req = rst_n & in_vld & ~tbl_full_r;
        force_al  = (defer_q == DEFER_MAX);
        grant_cxl = rst_n & cxl_vld & ~(force_al & alloc_req);
        grant_al  = alloc_req & ~grant_cxl;
        pop       = rst_n & tbl_mtr_vld_r & (~out_vld_q | out_accept);
    end

    always_comb begin
        defer_d = defer_q;
        if (grant_al || !alloc_req) begin
            defer_d = '0;
        end else if (grant_cxl && (defer_q != DEFER_MAX)) begin
            defer_d = defer_q + DW'(1);
        end
    end

    always_comb begin
        occ_d   = occ_q;
        err_d   = err_q;
        occ_sum = {2'b00, occ_q} + SW'(grant_al)
                  - SW'(grant_cxl & tbl_cancel_hit) - SW'(pop);
        if (occ_sum[SW-1] || (occ_sum > OCC_MAX)) begin
            err_d = 1'b1;
        end else begin
            occ_d = occ_sum[OW-1:0];
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_cmd_d = out_cmd_q;
        if (pop) begin
            out_vld_d = 1'b1;
            out_cmd_d = tbl_mtr_r;
        end else if (out_accept) begin
            out_vld_d = 1'b0;
        end
    end

    // uid/hit hold their last value between responses; only meaningful with rsp valid.
    always_comb begin
        rsp_vld_d = grant_cxl;
        rsp_uid_d = rsp_uid_q;
        rsp_hit_d = rsp_hit_q;
        if (grant_cxl) begin
            rsp_uid_d = cxl_uid;
            rsp_hit_d = tbl_cancel_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defer_q   <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_cmd_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_uid_q <= '0;
            rsp_hit_q <= 1'b0;
        end else begin
            defer_q   <= defer_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
            out_vld_q <= out_vld_d;
            out_cmd_q <= out_cmd_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_uid_q <= rsp_uid_d;
            rsp_hit_q <= rsp_hit_d;
        end
    end

    assign in_accept      = grant_al;
    assign tbl_cmd_vld    = grant_al;
    assign tbl_cmd        = in_cmd;
    assign cxl_accept     = grant_cxl;
    assign tbl_cancel     = grant_cxl;
    assign tbl_cancel_uid = cxl_uid;
    assign tbl_mtr_accept = pop;
    assign out_vld_r      = out_vld_q;
    assign out_cmd_r      = out_cmd_q;
    assign occ_r          = occ_q;
    assign err_r          = err_q;
    assign cxl_rsp_vld_r  = rsp_vld_q;
    assign cxl_rsp_uid_r  = rsp_uid_q;
    assign cxl_rsp_hit_r  = rsp_hit_q;

endmodule
